// File: rtl/queue_pkg.sv
// Shared sizing helpers for the queue_param FIFO and its pointer counters.
// Latency: n/a (compile-time constants only).
// Backpressure: n/a.
package queue_pkg;

    // Pointer width: index bits plus one wrap bit, so full and empty can be told apart.
    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    // Occupancy counter must represent 0..DEPTH inclusive, which needs the same width as a pointer.
    function automatic int count_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/queue_ptr.sv
// Wrap-bit pointer counter used for both the read and the write side of the FIFO.
// Latency: the pointer advances one cycle after inc is sampled.
// Backpressure: none; the caller only pulses inc on an accepted handshake.
module queue_ptr #(
    parameter int PTR_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [PTR_W-1:0] ptr
);

    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] ptr_d;

    // Next pointer: reset and clear both return to zero, otherwise step and wrap modulo 2*DEPTH.
    always_comb begin
        ptr_d = ptr_q;
        if (clr) begin
            ptr_d = '0;
        end else if (inc) begin
            ptr_d = ptr_q + 1'b1;
        end
    end

    // Pointer register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;

endmodule

// File: rtl/queue_param.sv
// Show-ahead synchronous FIFO with valid/ready on both push and pop sides.
// Latency: a pushed word is visible on DATA_OUT one cycle later; no fall-through when empty.
// Backpressure: push_ready drops when full and pop_valid drops when empty, both from registered state only.
module queue_param
    import queue_pkg::*;
#(
    parameter int LENGTH = 32,
    parameter int DEPTH  = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush,
    input  logic                        push_valid,
    output logic                        push_ready,
    input  logic [LENGTH-1:0]           DATA_IN,
    output logic                        pop_valid,
    input  logic                        pop_ready,
    output logic [LENGTH-1:0]           DATA_OUT,
    output logic [count_w(DEPTH)-1:0]   count
);

    localparam int PTR_W = ptr_w(DEPTH);
    localparam int CNT_W = count_w(DEPTH);
    localparam int IDX_W = PTR_W - 1;

    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [IDX_W-1:0]  wr_idx;
    logic [IDX_W-1:0]  rd_idx;
    logic              empty;
    logic              full;
    logic              push_fire;
    logic              pop_fire;
    logic              wr_en;
    logic [CNT_W-1:0]  count_q;
    logic [CNT_W-1:0]  count_d;
    logic [LENGTH-1:0] mem_q [DEPTH];

    assign wr_idx = wr_ptr[IDX_W-1:0];
    assign rd_idx = rd_ptr[IDX_W-1:0];

    // Same index with differing wrap bits means the writer is a full lap ahead.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_idx == rd_idx) && (wr_ptr[PTR_W-1] != rd_ptr[PTR_W-1]);

    assign push_ready = !full;
    assign pop_valid  = !empty;
    assign push_fire  = push_valid && push_ready;
    assign pop_fire   = pop_valid && pop_ready;

    // A flush or reset cycle drops the offered word, so memory must not be written then either.
    assign wr_en = push_fire && !flush && !rst;

    queue_ptr #(.PTR_W(PTR_W)) u_wr_ptr (
        .clk (clk),
        .rst (rst),
        .clr (flush),
        .inc (push_fire),
        .ptr (wr_ptr)
    );

    queue_ptr #(.PTR_W(PTR_W)) u_rd_ptr (
        .clk (clk),
        .rst (rst),
        .clr (flush),
        .inc (pop_fire),
        .ptr (rd_ptr)
    );

    // Storage array; deliberately not reset, stale contents are masked by the pointers.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_idx] <= DATA_IN;
        end
    end

    // Occupancy: flush empties, otherwise +1 on push only, -1 on pop only.
    always_comb begin
        count_d = count_q;
        if (flush) begin
            count_d = '0;
        end else begin
            case ({push_fire, pop_fire})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // Occupancy register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count    = count_q;
    assign DATA_OUT = pop_valid ? mem_q[rd_idx] : '0;

endmodule

// File: tb/tb_queue_param.sv
// Directed bench for queue_param: reset, fill, drain, wrap with concurrency, flush and reset priority.
// Latency: checks the one-cycle push-to-visible delay.
// Backpressure: exercises full/empty handshake refusal.
module tb_queue_param;

    localparam int LENGTH = 32;
    localparam int DEPTH  = 8;

    logic              clk;
    logic              rst;
    logic              flush;
    logic              push_valid;
    logic              push_ready;
    logic [LENGTH-1:0] DATA_IN;
    logic              pop_valid;
    logic              pop_ready;
    logic [LENGTH-1:0] DATA_OUT;
    logic [3:0]        count;

    int errors;
    int checks;

    logic [LENGTH-1:0] model_q [$];

    queue_param #(.LENGTH(LENGTH), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .push_valid (push_valid),
        .push_ready (push_ready),
        .DATA_IN    (DATA_IN),
        .pop_valid  (pop_valid),
        .pop_ready  (pop_ready),
        .DATA_OUT   (DATA_OUT),
        .count      (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one cycle and sample 1 time unit after the edge; also check the pointer/count invariant.
    task automatic step();
        logic [3:0] diff;
        @(posedge clk);
        #1;
        diff = dut.wr_ptr - dut.rd_ptr;
        checks++;
        if (count !== diff) begin
            errors++;
            $display("FAIL count_vs_ptrs: count=%0d ptr_diff=%0d", count, diff);
        end
    endtask

    task automatic idle_inputs();
        rst        = 1'b0;
        flush      = 1'b0;
        push_valid = 1'b0;
        pop_ready  = 1'b0;
        DATA_IN    = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        #1;
        checks++;
        if (push_ready !== 1'b1) begin errors++; $display("FAIL reset_push_ready: got=%b exp=1", push_ready); end
        checks++;
        if (pop_valid !== 1'b0) begin errors++; $display("FAIL reset_pop_valid: got=%b exp=0", pop_valid); end
        checks++;
        if (count !== 4'd0) begin errors++; $display("FAIL reset_count: got=%0d exp=0", count); end
        checks++;
        if (DATA_OUT !== 32'h0) begin errors++; $display("FAIL reset_data_out: got=%h exp=0", DATA_OUT); end
    endtask

    task automatic test_fill();
        pop_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            push_valid = 1'b1;
            DATA_IN    = 32'((i + 1) * 32'h11);
            step();
            checks++;
            if (count !== 4'(i + 1)) begin errors++; $display("FAIL fill_count[%0d]: got=%0d exp=%0d", i, count, i + 1); end
        end
        checks++;
        if (push_ready !== 1'b0) begin errors++; $display("FAIL fill_full_ready: got=%b exp=0", push_ready); end
        DATA_IN = 32'h99;
        step();
        push_valid = 1'b0;
        checks++;
        if (count !== 4'd8) begin errors++; $display("FAIL fill_ninth_push: count got=%0d exp=8", count); end
        checks++;
        if (DATA_OUT !== 32'h11) begin errors++; $display("FAIL fill_head: got=%h exp=11", DATA_OUT); end
    endtask

    task automatic test_drain();
        push_valid = 1'b0;
        pop_ready  = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            checks++;
            if (DATA_OUT !== 32'((i + 1) * 32'h11)) begin
                errors++;
                $display("FAIL drain_order[%0d]: got=%h exp=%h", i, DATA_OUT, 32'((i + 1) * 32'h11));
            end
            step();
        end
        pop_ready = 1'b0;
        checks++;
        if (pop_valid !== 1'b0) begin errors++; $display("FAIL drain_pop_valid: got=%b exp=0", pop_valid); end
        checks++;
        if (count !== 4'd0) begin errors++; $display("FAIL drain_count: got=%0d exp=0", count); end
    endtask

    task automatic test_wrap();
        logic [LENGTH-1:0] w;
        model_q.delete();
        pop_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            push_valid = 1'b1;
            w = 32'h200 + 32'(k);
            DATA_IN = w;
            // No fall-through: the queue is empty on the very first push.
            if (k == 0) begin
                checks++;
                if (pop_valid !== 1'b0) begin errors++; $display("FAIL no_fallthrough: pop_valid=%b exp=0", pop_valid); end
            end
            model_q.push_back(w);
            step();
        end
        pop_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            w = 32'h300 + 32'(k);
            DATA_IN = w;
            checks++;
            if (DATA_OUT !== model_q[0]) begin errors++; $display("FAIL wrap_order[%0d]: got=%h exp=%h", k, DATA_OUT, model_q[0]); end
            void'(model_q.pop_front());
            model_q.push_back(w);
            step();
            checks++;
            if (count !== 4'd3) begin errors++; $display("FAIL wrap_count[%0d]: got=%0d exp=3", k, count); end
        end
        pop_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            w = 32'h400 + 32'(k);
            DATA_IN = w;
            model_q.push_back(w);
            step();
        end
        checks++;
        if (push_ready !== 1'b0 || count !== 4'd8) begin
            errors++;
            $display("FAIL wrap_full: push_ready=%b count=%0d exp ready=0 count=8", push_ready, count);
        end
        // Full with both sides active: pop happens, push is refused.
        DATA_IN   = 32'hDEAD;
        pop_ready = 1'b1;
        void'(model_q.pop_front());
        step();
        push_valid = 1'b0;
        pop_ready  = 1'b0;
        checks++;
        if (count !== 4'd7) begin errors++; $display("FAIL full_pop_push_count: got=%0d exp=7", count); end
        checks++;
        if (push_ready !== 1'b1) begin errors++; $display("FAIL full_pop_ready_back: got=%b exp=1", push_ready); end
        pop_ready = 1'b1;
        for (int k = 0; k < 7; k++) begin
            checks++;
            if (DATA_OUT !== model_q[0]) begin errors++; $display("FAIL full_drain[%0d]: got=%h exp=%h", k, DATA_OUT, model_q[0]); end
            void'(model_q.pop_front());
            step();
        end
        pop_ready = 1'b0;
        checks++;
        if (pop_valid !== 1'b0) begin errors++; $display("FAIL full_drain_empty: pop_valid=%b exp=0", pop_valid); end
    endtask

    task automatic test_flush();
        pop_ready  = 1'b0;
        push_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            DATA_IN = 32'h500 + 32'(k);
            step();
        end
        checks++;
        if (count !== 4'd5) begin errors++; $display("FAIL flush_setup_count: got=%0d exp=5", count); end
        flush     = 1'b1;
        DATA_IN   = 32'hAB;
        pop_ready = 1'b1;
        step();
        flush      = 1'b0;
        push_valid = 1'b0;
        pop_ready  = 1'b0;
        checks++;
        if (count !== 4'd0) begin errors++; $display("FAIL flush_count: got=%0d exp=0", count); end
        checks++;
        if (pop_valid !== 1'b0) begin errors++; $display("FAIL flush_pop_valid: got=%b exp=0", pop_valid); end
        checks++;
        if (dut.wr_ptr !== 4'd0) begin errors++; $display("FAIL flush_wr_ptr: got=%0d exp=0", dut.wr_ptr); end
        push_valid = 1'b1;
        DATA_IN    = 32'hCD;
        step();
        push_valid = 1'b0;
        checks++;
        if (pop_valid !== 1'b1 || DATA_OUT !== 32'hCD) begin
            errors++;
            $display("FAIL flush_next_push: pop_valid=%b data=%h exp valid=1 data=cd", pop_valid, DATA_OUT);
        end
        checks++;
        if (count !== 4'd1) begin errors++; $display("FAIL flush_next_count: got=%0d exp=1", count); end
    endtask

    task automatic test_reset_mid();
        pop_ready  = 1'b0;
        push_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            DATA_IN = 32'h600 + 32'(k);
            step();
        end
        checks++;
        if (count !== 4'd4) begin errors++; $display("FAIL rstmid_setup_count: got=%0d exp=4", count); end
        rst     = 1'b1;
        DATA_IN = 32'hEE;
        step();
        rst        = 1'b0;
        push_valid = 1'b0;
        checks++;
        if (count !== 4'd0) begin errors++; $display("FAIL rstmid_count: got=%0d exp=0", count); end
        checks++;
        if (pop_valid !== 1'b0 || DATA_OUT !== 32'h0) begin
            errors++;
            $display("FAIL rstmid_empty: pop_valid=%b data=%h exp valid=0 data=0", pop_valid, DATA_OUT);
        end
        push_valid = 1'b1;
        DATA_IN    = 32'h77;
        step();
        push_valid = 1'b0;
        checks++;
        if (DATA_OUT !== 32'h77 || count !== 4'd1 || dut.wr_ptr !== 4'd1) begin
            errors++;
            $display("FAIL rstmid_next_push: data=%h count=%0d wr_ptr=%0d exp data=77 count=1 wr_ptr=1",
                     DATA_OUT, count, dut.wr_ptr);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        idle_inputs();
        test_reset();
        test_fill();
        test_drain();
        test_wrap();
        test_flush();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
